// File: rtl/pdm_decimator.sv
// PDM-to-PCM decimator: counts ones over a fixed window of M_CLK strobes and
// presents the signed sample on a single-entry valid/ready output register.
module pdm_decimator #(
   parameter int DECIMATION = 64,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_clk_rising,
   input  logic                 M_DATA,
   input  logic                 en,
   output logic [OUT_WIDTH-1:0] pcm_data,
   output logic                 pcm_valid,
   input  logic                 pcm_ready,
   output logic                 overflow
);

   localparam int CW = $clog2(DECIMATION);

   generate
      if (DECIMATION < 4 || DECIMATION > 1024 ||
          (DECIMATION & (DECIMATION - 1)) != 0) begin : g_bad_decimation
         $error("DECIMATION must be a power of two in 4..1024");
      end
      if (OUT_WIDTH < CW + 2) begin : g_bad_width
         $error("OUT_WIDTH must be at least $clog2(DECIMATION)+2");
      end
   endgenerate

   logic                 sync1;
   logic                 pdm_s;
   logic [CW:0]          ones;
   logic [CW-1:0]        bit_cnt;
   logic                 capture;
   logic                 complete;
   logic [CW:0]          total;
   logic [OUT_WIDTH-1:0] sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         pdm_s <= 1'b0;
      end else begin
         sync1 <= M_DATA;
         pdm_s <= sync1;
      end
   end

   always_comb begin
      capture  = m_clk_rising && en;
      complete = capture && (bit_cnt == CW'(DECIMATION - 1));
      total    = ones + {{CW{1'b0}}, pdm_s};
      // 2*ones - DECIMATION, wrapping into two's complement at OUT_WIDTH
      sample   = OUT_WIDTH'({total, 1'b0}) - OUT_WIDTH'(DECIMATION);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         ones    <= '0;
         bit_cnt <= '0;
      end else if (capture) begin
         if (complete) begin
            ones    <= '0;
            bit_cnt <= '0;
         end else begin
            ones    <= total;
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (complete) begin
         if (!pcm_valid || pcm_ready) begin
            pcm_data  <= sample;
            pcm_valid <= 1'b1;
         end else begin
            overflow  <= 1'b1;
         end
      end else if (pcm_valid && pcm_ready) begin
         pcm_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pdm_decimator.sv
// Randomized and directed bench for pdm_decimator against a window-queue reference model.
module tb_pdm_decimator;

   localparam int D = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_clk_rising = 1'b0;
   logic        M_DATA = 1'b0;
   logic        en = 1'b1;
   logic [15:0] pcm_data;
   logic        pcm_valid;
   logic        pcm_ready = 1'b0;
   logic        overflow;

   int vectors = 0;
   int miscompares = 0;
   bit rand_ready = 1'b0;

   bit          win[$];
   logic [15:0] exp_data = '0;
   logic        exp_valid = 1'b0;
   logic        exp_ovf = 1'b0;

   pdm_decimator #(.DECIMATION(D), .OUT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .m_clk_rising(m_clk_rising), .M_DATA(M_DATA),
      .en(en), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
      .pcm_ready(pcm_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a window is the list of bits captured since the last close/clear.
   task automatic model_edge();
      bit done = 1'b0;
      int s = 0;
      if (rst) begin
         win.delete();
         exp_valid = 1'b0;
         exp_data  = '0;
         exp_ovf   = 1'b0;
         return;
      end
      if (!en) win.delete();
      else if (m_clk_rising) begin
         win.push_back(M_DATA);
         if (win.size() == D) begin
            foreach (win[i]) s += int'(win[i]);
            s = 2 * s - D;
            done = 1'b1;
            win.delete();
         end
      end
      if (done) begin
         if (!exp_valid || pcm_ready) begin
            exp_data  = 16'(s);
            exp_valid = 1'b1;
         end else exp_ovf = 1'b1;
      end else if (exp_valid && pcm_ready) exp_valid = 1'b0;
   endtask

   task automatic step();
      if (rand_ready) pcm_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("valid", 32'(pcm_valid), 32'(exp_valid));
      check("data", 32'(pcm_data), 32'(exp_data));
      check("overflow", 32'(overflow), 32'(exp_ovf));
   endtask

   // M_DATA is held 3 cycles before the strobe so the synchronizer has settled.
   task automatic strobe_cycle(input logic b, input logic r_idle, input logic r_stb);
      M_DATA = b;
      m_clk_rising = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pcm_ready = r_idle;
         step();
      end
      m_clk_rising = 1'b1;
      pcm_ready = r_stb;
      step();
      m_clk_rising = 1'b0;
   endtask

   task automatic window_const(input logic b, input logic r);
      for (int i = 0; i < D; i++) strobe_cycle(b, r, r);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check("reset_data", 32'(pcm_data), 32'h0);
      check("reset_valid", 32'(pcm_valid), 32'h0);
      check("reset_ovf", 32'(overflow), 32'h0);

      window_const(1'b1, 1'b1);
      check("ones_valid", 32'(pcm_valid), 32'h1);
      check("ones_data", 32'(pcm_data), 32'h0040);
      step();
      check("ones_pulse", 32'(pcm_valid), 32'h0);

      window_const(1'b0, 1'b1);
      check("zeros_data", 32'(pcm_data), 32'hFFC0);
      for (int i = 0; i < D; i++) strobe_cycle(1'(i % 2 == 0), 1'b1, 1'b1);
      check("alt_data", 32'(pcm_data), 32'h0000);
      for (int i = 0; i < D; i++) strobe_cycle(1'(i < 48), 1'b1, 1'b1);
      check("48_data", 32'(pcm_data), 32'h0020);
      step();

      window_const(1'b1, 1'b0);
      check("bp_held", 32'(pcm_data), 32'h0040);
      window_const(1'b0, 1'b0);
      check("bp_kept", 32'(pcm_data), 32'h0040);
      check("bp_valid", 32'(pcm_valid), 32'h1);
      check("bp_ovf", 32'(overflow), 32'h1);
      pcm_ready = 1'b1;
      step();
      check("bp_drain", 32'(pcm_valid), 32'h0);

      window_const(1'b1, 1'b0);
      for (int i = 0; i < D; i++) strobe_cycle(1'b0, 1'b0, 1'(i == D - 1));
      check("hs_valid", 32'(pcm_valid), 32'h1);
      check("hs_data", 32'(pcm_data), 32'hFFC0);
      check("hs_ovf", 32'(overflow), 32'h1);

      for (int i = 0; i < 30; i++) strobe_cycle(1'b1, 1'b1, 1'b1);
      pulse_reset();
      check("mid_rst_data", 32'(pcm_data), 32'h0);
      check("mid_rst_ovf", 32'(overflow), 32'h0);
      for (int i = 0; i < D - 1; i++) strobe_cycle(1'b1, 1'b1, 1'b1);
      check("mid_rst_early", 32'(pcm_valid), 32'h0);
      strobe_cycle(1'b1, 1'b1, 1'b1);
      check("mid_rst_valid", 32'(pcm_valid), 32'h1);
      check("mid_rst_value", 32'(pcm_data), 32'h0040);

      for (int i = 0; i < 20; i++) strobe_cycle(1'b0, 1'b1, 1'b1);
      en = 1'b0;
      for (int i = 0; i < 10; i++) strobe_cycle(1'b0, 1'b1, 1'b1);
      en = 1'b1;
      for (int i = 0; i < D - 1; i++) strobe_cycle(1'b1, 1'b1, 1'b1);
      check("en_early", 32'(pcm_valid), 32'h0);
      strobe_cycle(1'b1, 1'b0, 1'b0);
      check("en_valid", 32'(pcm_data), 32'h0040);
      window_const(1'b0, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 10; i++) strobe_cycle(1'b1, 1'b0, 1'b0);
      check("en_hold_valid", 32'(pcm_valid), 32'h1);
      check("en_hold_data", 32'(pcm_data), 32'h0040);
      check("en_hold_ovf", 32'(overflow), 32'h1);
      en = 1'b1;

      rand_ready = 1'b1;
      for (int i = 0; i < 20 * D; i++) begin
         if ($urandom_range(0, 399) == 0) pulse_reset();
         en = 1'($urandom_range(0, 60) != 0);
         strobe_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
